// File: rtl/nfa_drv_pkg.sv
// ---------------------------------------------------------------------------
// nfa_drv_pkg : shared state encoding and defaults for the NFA stream driver
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package nfa_drv_pkg;
  localparam int DEF_OFS_W   = 16;
  localparam int DEF_ENG_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SOD    = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } state_t;
endpackage

`default_nettype wire

// File: rtl/nfa_stream_driver_if.sv
// ---------------------------------------------------------------------------
// nfa_stream_driver_if : byte stream, engine drive and match record bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface nfa_stream_driver_if
  import nfa_drv_pkg::*;
#(
  parameter int N_ENG = 8,
  parameter int OFS_W = DEF_OFS_W
);
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_data;
  logic             s_sop;
  logic             s_eop;
  logic             eng_sod;
  logic             eng_en;
  logic [7:0]       eng_char;
  logic [N_ENG-1:0] eng_out;
  logic             r_valid;
  logic             r_ready;
  logic [N_ENG-1:0] r_match;
  logic             r_any;
  logic [OFS_W-1:0] r_first_ofs;
  logic [OFS_W-1:0] r_len;
  logic             r_err;

  modport master (
    input  s_valid, s_data, s_sop, s_eop, eng_out, r_ready,
    output s_ready, eng_sod, eng_en, eng_char,
           r_valid, r_match, r_any, r_first_ofs, r_len, r_err
  );

  modport slave (
    output s_valid, s_data, s_sop, s_eop, eng_out, r_ready,
    input  s_ready, eng_sod, eng_en, eng_char,
           r_valid, r_match, r_any, r_first_ofs, r_len, r_err
  );
endinterface

`default_nettype wire

// File: rtl/nfa_match_capture.sv
// ---------------------------------------------------------------------------
// nfa_match_capture : offset delay line matched to engine latency, first-rise
//                     detect and end-of-packet snapshot of the engine outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nfa_match_capture
  import nfa_drv_pkg::*;
#(
  parameter int N_ENG   = 8,
  parameter int OFS_W   = DEF_OFS_W,
  parameter int ENG_LAT = DEF_ENG_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             snap,
  input  logic [OFS_W-1:0] tag_ofs,
  input  logic [N_ENG-1:0] eng_out,
  output logic [N_ENG-1:0] match,
  output logic [OFS_W-1:0] first_ofs
);
  logic [OFS_W-1:0] dly [ENG_LAT];
  logic             found;
  logic [OFS_W-1:0] found_ofs;
  logic [OFS_W-1:0] first_now;

  // The snapshot cycle may itself be the first rise, so resolve it combinationally.
  always_comb begin
    first_now = '1;
    if (found)
      first_now = found_ofs;
    else if (|eng_out)
      first_now = dly[ENG_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < ENG_LAT; i++) dly[i] <= '0;
      found     <= 1'b0;
      found_ofs <= '0;
    end else begin
      dly[0] <= tag_ofs;
      for (int i = 1; i < ENG_LAT; i++) dly[i] <= dly[i-1];
      if (|eng_out && !found) begin
        found     <= 1'b1;
        found_ofs <= dly[ENG_LAT-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match     <= '0;
      first_ofs <= '0;
    end else if (snap) begin
      match     <= eng_out;
      first_ofs <= first_now;
    end
  end
endmodule

`default_nettype wire

// File: rtl/nfa_stream_driver.sv
// ---------------------------------------------------------------------------
// nfa_stream_driver : packet stream to NFA engine bank driver, one match record
//                     per packet. NFA_DRV_STATS_EN adds stat_pkts/stat_hits.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nfa_stream_driver
  import nfa_drv_pkg::*;
#(
  parameter int N_ENG   = 8,
  parameter int OFS_W   = DEF_OFS_W,
  parameter int ENG_LAT = DEF_ENG_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  nfa_stream_driver_if.master  bus
`ifdef NFA_DRV_STATS_EN
  ,
  output logic [31:0]          stat_pkts,
  output logic [31:0]          stat_hits
`endif
);
  localparam int CW = $clog2(ENG_LAT + 1);

  state_t           state;
  logic [7:0]       hold_data;
  logic             hold_eop;
  logic [OFS_W-1:0] drv_ofs;
  logic [OFS_W-1:0] len_cnt;
  logic             pkt_err;
  logic [CW-1:0]    drain_cnt;
  logic             snap;

  assign snap = (state == ST_DRAIN) && (drain_cnt == CW'(ENG_LAT));

  nfa_match_capture #(
    .N_ENG   (N_ENG),
    .OFS_W   (OFS_W),
    .ENG_LAT (ENG_LAT)
  ) u_capture (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == ST_SOD),
    .snap      (snap),
    .tag_ofs   (drv_ofs),
    .eng_out   (bus.eng_out),
    .match     (bus.r_match),
    .first_ofs (bus.r_first_ofs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bus.s_ready  <= 1'b0;
      bus.eng_sod  <= 1'b1;
      bus.eng_en   <= 1'b0;
      bus.eng_char <= '0;
      bus.r_valid  <= 1'b0;
      bus.r_any    <= 1'b0;
      bus.r_len    <= '0;
      bus.r_err    <= 1'b0;
      hold_data    <= '0;
      hold_eop     <= 1'b0;
      drv_ofs      <= '0;
      len_cnt      <= '0;
      pkt_err      <= 1'b0;
      drain_cnt    <= '0;
    end else begin
      bus.eng_en  <= 1'b0;
      bus.eng_sod <= 1'b0;
      case (state)
        ST_IDLE: begin
          bus.s_ready <= 1'b1;
          if (bus.s_valid && bus.s_ready && bus.s_sop) begin
            hold_data   <= bus.s_data;
            hold_eop    <= bus.s_eop;
            bus.s_ready <= 1'b0;
            bus.eng_sod <= 1'b1;
            state       <= ST_SOD;
          end
        end
        ST_SOD: begin
          bus.eng_en   <= 1'b1;
          bus.eng_char <= hold_data;
          drv_ofs      <= '0;
          len_cnt      <= OFS_W'(1);
          pkt_err      <= 1'b0;
          drain_cnt    <= '0;
          if (hold_eop) begin
            state <= ST_DRAIN;
          end else begin
            bus.s_ready <= 1'b1;
            state       <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (bus.s_valid) begin
            bus.eng_en   <= 1'b1;
            bus.eng_char <= bus.s_data;
            drv_ofs      <= (drv_ofs == '1) ? drv_ofs : drv_ofs + 1'b1;
            len_cnt      <= (len_cnt == '1) ? len_cnt : len_cnt + 1'b1;
            if (bus.s_sop) pkt_err <= 1'b1;
            if (bus.s_eop) begin
              bus.s_ready <= 1'b0;
              drain_cnt   <= '0;
              state       <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (snap) begin
            bus.r_valid <= 1'b1;
            bus.r_any   <= |bus.eng_out;
            bus.r_len   <= len_cnt;
            bus.r_err   <= pkt_err;
            state       <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (bus.r_ready) begin
            bus.r_valid <= 1'b0;
            bus.s_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef NFA_DRV_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts <= '0;
      stat_hits <= '0;
    end else if (bus.r_valid && bus.r_ready) begin
      stat_pkts <= stat_pkts + 1'b1;
      if (bus.r_any) stat_hits <= stat_hits + 1'b1;
    end
  end
`endif
endmodule

`default_nettype wire

// File: tb/tb_nfa_stream_driver.sv
// ---------------------------------------------------------------------------
// tb_nfa_stream_driver : self-checking bench with a '-'+hex-digit engine model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_nfa_stream_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nfa_stream_driver_if #(.N_ENG(8), .OFS_W(16)) bus ();

`ifdef NFA_DRV_STATS_EN
  logic [31:0] stat_pkts, stat_hits;
  nfa_stream_driver #(.N_ENG(8), .OFS_W(16), .ENG_LAT(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stat_pkts(stat_pkts), .stat_hits(stat_hits));
`else
  nfa_stream_driver #(.N_ENG(8), .OFS_W(16), .ENG_LAT(2)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  int total = 0;
  int bad   = 0;

  function automatic bit is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "a" && c <= "f");
  endfunction

  // Engine on bit 0: sticky hit on '-' followed by a lowercase hex digit, 2-cycle latency.
  logic [7:0] e_prev;
  logic       e_p1;
  logic [7:0] e_out;
  always @(posedge clk) begin
    if (bus.eng_sod) begin
      e_prev <= 8'd0; e_p1 <= 1'b0; e_out <= 8'd0;
    end else begin
      if (bus.eng_en) begin
        e_p1   <= (e_prev == "-") && is_hex(bus.eng_char);
        e_prev <= bus.eng_char;
      end else begin
        e_p1 <= 1'b0;
      end
      e_out[0] <= e_out[0] | e_p1;
    end
  end
  assign bus.eng_out = e_out;

  typedef struct {
    logic [7:0]  match;
    logic        any;
    logic [15:0] first;
    logic [15:0] len;
    logic        err;
  } rec_t;
  rec_t recs[$];

  bit rr_hold = 1'b0;
  bit rr_rand = 1'b0;
  initial bus.r_ready = 1'b0;
  always @(posedge clk) begin
    #2;
    bus.r_ready = rr_hold ? 1'b0 : (rr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  always @(negedge clk)
    if (!rst && bus.r_valid && bus.r_ready)
      recs.push_back('{bus.r_match, bus.r_any, bus.r_first_ofs, bus.r_len, bus.r_err});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_rec(input string tag, input rec_t g, input rec_t e);
    check({tag, ".match"}, 32'(g.match), 32'(e.match));
    check({tag, ".any"},   32'(g.any),   32'(e.any));
    check({tag, ".first"}, 32'(g.first), 32'(e.first));
    check({tag, ".len"},   32'(g.len),   32'(e.len));
    check({tag, ".err"},   32'(g.err),   32'(e.err));
  endtask

  task automatic wait_rec(input string tag, output rec_t r, output bit ok);
    int n = 0;
    while (recs.size() == 0 && n < 200) begin
      @(negedge clk); n++;
    end
    ok = (recs.size() != 0);
    r  = '{8'd0, 1'b0, 16'd0, 16'd0, 1'b0};
    if (ok) r = recs.pop_front();
    else begin
      total++; bad++;
      $display("FAIL %s.timeout: got no record expected one within 200 cycles", tag);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input bit sop, input bit eop);
    int n = 0;
    @(negedge clk);
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_sop = sop; bus.s_eop = eop;
    while (!bus.s_ready && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL beat_timeout: got s_ready=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.s_valid = 1'b0; bus.s_sop = 1'b0; bus.s_eop = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b[$], input logic sm[$], input bit gaps);
    for (int i = 0; i < b.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle_cycle();
      send_beat(b[i], (i == 0) || sm[i], i == b.size() - 1);
    end
    idle_cycle();
  endtask

  // Reference: scan the packet for the first '-' immediately followed by a hex digit.
  function automatic rec_t model(input logic [7:0] b[$], input logic sm[$]);
    rec_t e = '{8'd0, 1'b0, 16'hFFFF, 16'(b.size()), 1'b0};
    for (int i = 1; i < b.size(); i++) begin
      if (!e.any && b[i-1] == "-" && is_hex(b[i])) begin
        e.any = 1'b1; e.first = 16'(i); e.match = 8'd1;
      end
      if (sm[i]) e.err = 1'b1;
    end
    return e;
  endfunction

  typedef struct {
    logic [63:0] s;
    int          n;
    logic [7:0]  sopm;
    logic        any;
    logic [15:0] first;
    logic        err;
  } vec_t;
  vec_t tv[8];

  initial begin
    rec_t r, e, snap0;
    bit ok;
    logic [7:0] q[$];
    logic sm[$];
    logic [7:0] alpha[10];
    int sod_n, en_n, drain_n, n;

    bus.s_valid = 1'b0; bus.s_data = 8'd0; bus.s_sop = 1'b0; bus.s_eop = 1'b0;

    tv[0] = '{"ab-7z", 5, 8'h00, 1'b1, 16'd3,    1'b0};
    tv[1] = '{"a-g",   3, 8'h00, 1'b0, 16'hFFFF, 1'b0};
    tv[2] = '{"-",     1, 8'h00, 1'b0, 16'hFFFF, 1'b0};
    tv[3] = '{"-a",    2, 8'h00, 1'b1, 16'd1,    1'b0};
    tv[4] = '{"x-f-1", 5, 8'h00, 1'b1, 16'd2,    1'b0};
    tv[5] = '{"--5",   3, 8'h02, 1'b1, 16'd2,    1'b1};
    tv[6] = '{"9-",    2, 8'h00, 1'b0, 16'hFFFF, 1'b0};
    tv[7] = '{"-0-b",  4, 8'h08, 1'b1, 16'd1,    1'b1};

    repeat (3) @(negedge clk);
    check("rst.s_ready",  32'(bus.s_ready), 0);
    check("rst.eng_sod",  32'(bus.eng_sod), 1);
    check("rst.eng_en",   32'(bus.eng_en), 0);
    check("rst.eng_char", 32'(bus.eng_char), 0);
    check("rst.r_valid",  32'(bus.r_valid), 0);
    check("rst.r_match",  32'(bus.r_match), 0);
    check("rst.r_any",    32'(bus.r_any), 0);
    check("rst.r_first",  32'(bus.r_first_ofs), 0);
    check("rst.r_len",    32'(bus.r_len), 0);
    check("rst.r_err",    32'(bus.r_err), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      q.delete(); sm.delete();
      for (int k = 0; k < tv[i].n; k++) begin
        q.push_back(tv[i].s[8*(tv[i].n-1-k) +: 8]);
        sm.push_back(tv[i].sopm[k]);
      end
      send_pkt(q, sm, 1'b0);
      wait_rec($sformatf("vec%0d", i), r, ok);
      if (ok) cmp_rec($sformatf("vec%0d", i), r,
                      '{{7'd0, tv[i].any}, tv[i].any, tv[i].first, 16'(tv[i].n), tv[i].err});
    end

    // Single sop&eop beat: cycle-by-cycle engine-side sequence
    send_beat("-", 1'b1, 1'b1);
    sod_n = 0; en_n = 0; drain_n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) begin bus.s_valid = 1'b0; bus.s_sop = 1'b0; bus.s_eop = 1'b0; end
      if (bus.r_valid) break;
      if (bus.eng_sod) sod_n++;
      if (bus.eng_en) en_n++;
      if (en_n > 0 && !bus.eng_en && !bus.s_ready) drain_n++;
    end
    check("one.sod_cycles", 32'(sod_n), 1);
    check("one.en_cycles", 32'(en_n), 1);
    check("one.drain_cycles", 32'(drain_n), 2);
    wait_rec("one", r, ok);
    if (ok) cmp_rec("one", r, '{8'd0, 1'b0, 16'hFFFF, 16'd1, 1'b0});

    // Consumer stalls: record must hold and no new packet may start
    rr_hold = 1'b1;
    send_pkt('{"a", "b", "-", "7", "z"}, '{0, 0, 0, 0, 0}, 1'b0);
    n = 0;
    while (!bus.r_valid && n < 50) begin @(negedge clk); n++; end
    check("hold.r_valid_seen", 32'(bus.r_valid), 1);
    snap0 = '{bus.r_match, bus.r_any, bus.r_first_ofs, bus.r_len, bus.r_err};
    bus.s_valid = 1'b1; bus.s_data = "-"; bus.s_sop = 1'b1; bus.s_eop = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold.r_valid", 32'(bus.r_valid), 1);
      check("hold.stable", 32'({bus.r_match, bus.r_any, bus.r_first_ofs, bus.r_len, bus.r_err}
                               == {snap0.match, snap0.any, snap0.first, snap0.len, snap0.err}), 1);
      check("hold.s_ready", 32'(bus.s_ready), 0);
      check("hold.eng_sod", 32'(bus.eng_sod), 0);
    end
    rr_hold = 1'b0;
    n = 0;
    while (!bus.s_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.s_valid = 1'b0; bus.s_sop = 1'b0; bus.s_eop = 1'b0;
    wait_rec("hold.first", r, ok);
    if (ok) cmp_rec("hold.first", r, '{8'd1, 1'b1, 16'd3, 16'd5, 1'b0});
    wait_rec("hold.next", r, ok);
    if (ok) cmp_rec("hold.next", r, '{8'd0, 1'b0, 16'hFFFF, 16'd1, 1'b0});

    // Reset in the middle of a packet discards it
    send_beat("-", 1'b1, 1'b0);
    send_beat("-", 1'b0, 1'b0);
    idle_cycle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mrst.s_ready", 32'(bus.s_ready), 0);
    check("mrst.eng_sod", 32'(bus.eng_sod), 1);
    check("mrst.eng_en", 32'(bus.eng_en), 0);
    check("mrst.r_valid", 32'(bus.r_valid), 0);
    rst = 1'b0;
    send_beat("5", 1'b0, 1'b1);
    idle_cycle();
    repeat (10) @(negedge clk);
    check("mrst.no_record", 32'(recs.size()), 0);
    send_pkt('{"-", "a"}, '{0, 0}, 1'b0);
    wait_rec("mrst.next", r, ok);
    if (ok) cmp_rec("mrst.next", r, '{8'd1, 1'b1, 16'd1, 16'd2, 1'b0});

    // Leading non-sop beats in IDLE are dropped
    send_beat("x", 1'b0, 1'b0);
    send_beat("y", 1'b0, 1'b0);
    send_pkt('{"-", "F"}, '{0, 0}, 1'b0);
    wait_rec("drop", r, ok);
    if (ok) cmp_rec("drop", r, '{8'd0, 1'b0, 16'hFFFF, 16'd2, 1'b0});

    // Random packets against the reference scan
    alpha = '{"-", "-", "a", "b", "0", "5", "9", "g", "z", "F"};
    rr_rand = 1'b1;
    for (int p = 0; p < 40; p++) begin
      q.delete(); sm.delete();
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        q.push_back(alpha[$urandom_range(0, 9)]);
        sm.push_back(k > 0 && $urandom_range(0, 9) == 0);
      end
      for (int j = $urandom_range(0, 2); j > 0; j--) send_beat(alpha[$urandom_range(0, 9)], 1'b0, 1'b0);
      e = model(q, sm);
      send_pkt(q, sm, 1'b1);
      wait_rec($sformatf("rnd%0d", p), r, ok);
      if (ok) cmp_rec($sformatf("rnd%0d", p), r, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire
